// File: rtl/timer_ctrl.sv
// Work/break session sequencer for a mm:ss counter.
// Drives counter enable/clear, tracks completed work phases, raises a timed alarm.
module timer_ctrl #(
    parameter int ALARM_LEN = 16
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        start_btn,
    input  logic        stop_btn,
    input  logic [11:0] time_in,
    input  logic [5:0]  work_min,
    input  logic [5:0]  break_min,
    input  logic [3:0]  cycles,
    output logic        cnt_enable,
    output logic        cnt_clear,
    output logic [1:0]  mode,
    output logic        paused,
    output logic        alarm,
    output logic [3:0]  cycle_cnt
);

    typedef enum logic [2:0] {
        IDLE, WORK, WORK_P, BREAK, BREAK_P, ALARM
    } state_t;

    localparam logic [7:0] ALARM_LAST = 8'(ALARM_LEN - 1);

    state_t      state;
    logic        armed;
    logic        start_q;
    logic        stop_q;
    logic [5:0]  work_l;
    logic [5:0]  break_l;
    logic [3:0]  cyc_l;
    logic [7:0]  alarm_cnt;
    logic        start_ev;
    logic        stop_ev;
    logic [5:0]  lim;
    logic        phase_done;
    logic [3:0]  cycle_nxt;

    // armed stays low for the first cycle after reset so a held button is not an edge
    assign start_ev   = armed & start_btn & ~start_q;
    assign stop_ev    = armed & stop_btn & ~stop_q;
    assign lim        = (state == BREAK) ? break_l : work_l;
    assign phase_done = (time_in[11:6] >= lim) && (time_in[5:0] == 6'd0);
    assign cycle_nxt  = cycle_cnt + 4'd1;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= IDLE;
            armed      <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            work_l     <= 6'd1;
            break_l    <= 6'd1;
            cyc_l      <= 4'd1;
            alarm_cnt  <= 8'd0;
            cnt_enable <= 1'b0;
            cnt_clear  <= 1'b0;
            mode       <= 2'd0;
            paused     <= 1'b0;
            alarm      <= 1'b0;
            cycle_cnt  <= 4'd0;
        end else begin
            armed     <= 1'b1;
            start_q   <= start_btn;
            stop_q    <= stop_btn;
            cnt_clear <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start_ev && !stop_ev) begin
                        work_l    <= (work_min == 6'd0) ? 6'd1 : work_min;
                        break_l   <= (break_min == 6'd0) ? 6'd1 : break_min;
                        cyc_l     <= (cycles == 4'd0) ? 4'd1 : cycles;
                        cycle_cnt <= 4'd0;
                        cnt_clear <= 1'b1;
                        state     <= WORK;
                        mode      <= 2'd1;
                    end
                end
                WORK, BREAK: begin
                    if (stop_ev) begin
                        state      <= (state == WORK) ? WORK_P : BREAK_P;
                        cnt_enable <= 1'b0;
                        paused     <= 1'b1;
                    // time_in is stale while the clear pulse is still out
                    end else if (!cnt_clear && phase_done) begin
                        cnt_enable <= 1'b0;
                        cnt_clear  <= 1'b1;
                        if (state == WORK) begin
                            cycle_cnt <= cycle_nxt;
                            if (cycle_nxt == cyc_l) begin
                                state     <= ALARM;
                                mode      <= 2'd3;
                                alarm     <= 1'b1;
                                alarm_cnt <= 8'd0;
                            end else begin
                                state <= BREAK;
                                mode  <= 2'd2;
                            end
                        end else begin
                            state <= WORK;
                            mode  <= 2'd1;
                        end
                    end else begin
                        cnt_enable <= 1'b1;
                    end
                end
                WORK_P, BREAK_P: begin
                    if (stop_ev) begin
                        state     <= IDLE;
                        mode      <= 2'd0;
                        paused    <= 1'b0;
                        cnt_clear <= 1'b1;
                    end else if (start_ev) begin
                        state      <= (state == WORK_P) ? WORK : BREAK;
                        paused     <= 1'b0;
                        cnt_enable <= 1'b1;
                    end
                end
                ALARM: begin
                    if (start_ev || stop_ev || alarm_cnt == ALARM_LAST) begin
                        state     <= IDLE;
                        mode      <= 2'd0;
                        alarm     <= 1'b0;
                        cnt_clear <= 1'b1;
                    end else begin
                        alarm_cnt <= alarm_cnt + 8'd1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    mode       <= 2'd0;
                    paused     <= 1'b0;
                    alarm      <= 1'b0;
                    cnt_enable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/timer_ctrl.md
TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 The module SHALL expose parameter ALARM_LEN, default 16, giving the alarm duration in clk cycles (1..255).
REQ-002 The module SHALL have port clk, input, 1, system clock, with all state updated on its rising edge.
REQ-003 The module SHALL have port nrst, input, 1, reset, asynchronous, active-low.
REQ-004 The module SHALL have port start_btn, input, 1, start/resume level, already synchronized to clk.
REQ-005 The module SHALL have port stop_btn, input, 1, pause/abort level, already synchronized to clk.
REQ-006 The module SHALL have port time_in, input, 12, counter value {minutes[11:6], seconds[5:0]}.
REQ-007 The module SHALL have port work_min, input, 6, work-phase length in minutes.
REQ-008 The module SHALL have port break_min, input, 6, break-phase length in minutes.
REQ-009 The module SHALL have port cycles, input, 4, number of work phases per session.
REQ-010 The module SHALL have port cnt_enable, output, 1, drives counter enable.
REQ-011 The module SHALL have port cnt_clear, output, 1, drives counter clear.
REQ-012 The module SHALL have port mode, output, 2, phase indicator: 0 idle, 1 work, 2 break, 3 alarm.
REQ-013 The module SHALL have port paused, output, 1, high while in either pause state.
REQ-014 The module SHALL have port alarm, output, 1, high during the ALARM state.
REQ-015 The module SHALL have port cycle_cnt, output, 4, number of completed work phases.

Function
REQ-016 All outputs SHALL be registered.
REQ-017 start and stop SHALL be rising-edge detected internally; a held button SHALL generate one event.
REQ-018 The FSM SHALL have exactly these states: IDLE, WORK, WORK_P, BREAK, BREAK_P, ALARM.
REQ-019 When start and stop events coincide in the same cycle, stop SHALL win.
REQ-020 IDLE + start SHALL latch work_min, break_min and cycles, and set cycle_cnt=0.
REQ-021 A latched value of 0 SHALL be replaced by 1 for work_min, break_min and cycles.
REQ-022 IDLE + start SHALL pulse cnt_clear for one cycle, then go to WORK.
REQ-023 Configuration inputs SHALL be ignored outside that latch cycle.
REQ-024 In WORK and BREAK, cnt_enable SHALL be 1; in all other states it SHALL be 0.
REQ-025 WORK SHALL end on the first cycle with time_in[11:6] >= latched work_min and time_in[5:0] == 0.
REQ-026 At WORK end: cnt_enable SHALL drop, cnt_clear SHALL pulse one cycle, and cycle_cnt SHALL increment.
REQ-027 At WORK end, the next state SHALL be ALARM if the new cycle_cnt equals latched cycles, else BREAK.
REQ-028 BREAK SHALL end using the same compare against latched break_min.
REQ-029 At BREAK end, cnt_clear SHALL pulse and the next state SHALL be WORK; cycle_cnt SHALL be unchanged.
REQ-030 WORK/BREAK + stop SHALL go to WORK_P/BREAK_P.
REQ-031 In a pause state, the counter SHALL hold (no clear) and paused SHALL be 1.
REQ-032 Pause + start SHALL resume the same phase with no clear.
REQ-033 Pause + stop SHALL pulse cnt_clear and go to IDLE; cycle_cnt SHALL hold its value until the next start.
REQ-034 In ALARM, alarm SHALL be 1 for ALARM_LEN cycles, then the FSM SHALL go to IDLE.
REQ-035 A start or stop event in ALARM SHALL go to IDLE immediately.
REQ-036 Leaving ALARM SHALL pulse cnt_clear.
REQ-037 mode SHALL be 1 in WORK/WORK_P, 2 in BREAK/BREAK_P, 3 in ALARM and 0 in IDLE.
REQ-038 cnt_clear and cnt_enable SHALL never both be 1 in the same cycle.

Reset
REQ-039 On nrst low, asynchronously: state=IDLE, cnt_enable=0, cnt_clear=0, mode=0, paused=0, alarm=0, cycle_cnt=0, latched config=1, and edge detectors cleared.
REQ-040 Reset mid-phase SHALL abort the phase with no further clear pulse.
REQ-041 A button held high through reset release SHALL NOT generate an event.

Verification
REQ-042 work_min=1, break_min=1, cycles=2, start, counter model ticks -> WORK; at time_in=0x040, cnt_clear pulse and BREAK; at 0x040, WORK; at 0x040, cycle_cnt=2 and ALARM for 16 cycles, then IDLE.
REQ-043 In WORK at time_in=0x01E, stop -> WORK_P, paused=1, cnt_enable=0; then start -> WORK resumes with no clear pulse.
REQ-044 Start and stop rising in the same cycle during WORK -> WORK_P.
REQ-045 work_min=0, cycles=0, start -> phase ends at time_in=0x040, then ALARM (cycles treated as 1).
REQ-046 nrst asserted in BREAK -> all outputs at reset values immediately; start_btn held high across nrst release -> FSM stays in IDLE.
REQ-047 Every scenario -> assertion that cnt_clear and cnt_enable are never both 1.
